decode_stage: RTL
=================

# decode_stage

RV32I instruction decode stage sitting between fetch and execute and directly upstream of `register_file`. It accepts instructions over a valid/ready handshake and drives the register-file read addresses. It captures operands, decodes the immediate and control fields into a registered ID/EX output, and uses a per-register scoreboard to stall on RAW/WAW hazards until writeback retires the producer.

## Interface
- `NRegs`, 32: architectural register count and scoreboard size; register 0 is never tracked.
- Data and register-address widths are `RegWidth` (32) and `RegAddrWidth` (5) from `rv32_isa`.
- `iClk` in 1: clock, all state on rising edge.
- `nRst` in 1: asynchronous, active-low reset.
- `iValid` in 1: fetch presents an instruction.
- `oReady` out 1: decode accepts this cycle.
- `iInstr` in 32: instruction word.
- `iPC` in 32: instruction address.
- `oAddr_Rs1` out 5: register-file read address; combinational from `iInstr[19:15]`.
- `oAddr_Rs2` out 5: register-file read address; combinational from `iInstr[24:20]`.
- `iRs1` in 32: register-file read data.
- `iRs2` in 32: register-file read data.
- `iWbEn` in 1: writeback writes the register file this cycle.
- `iWbAddr` in 5: writeback destination.
- `iWbData` in 32: writeback data.
- `iClrEn` in 1: downstream killed an in-flight instruction; clear its scoreboard bit without writing.
- `iClrAddr` in 5: killed instruction's rd.
- `iFlush` in 1: kill the held output and the incoming instruction.
- `oValid` out 1: ID/EX register holds a valid instruction.
- `iReady` in 1: execute accepts.
- `oPC` out 32: registered ID/EX field.
- `oRs1Val` out 32: registered ID/EX field.
- `oRs2Val` out 32: registered ID/EX field.
- `oImm` out 32: registered ID/EX field.
- `oRdAddr` out 5: registered ID/EX field; 0 when the instruction writes no register.
- `oOpcode` out 7: registered ID/EX field.
- `oFunct3` out 3: registered ID/EX field.
- `oFunct7b5` out 1: registered ID/EX field.
- `oIllegal` out 1: registered ID/EX field.

## Operation
- Read rs1:
  - JALR, BRANCH, LOAD, STORE, OP-IMM, OP.
  - For non-readers the field is ignored for hazards and the operand value is 0.
- Read rs2: BRANCH, STORE, OP. For non-readers the field is ignored for hazards and the operand value is 0.
- Write rd: LUI, AUIPC, JAL, JALR, LOAD, OP-IMM, OP. rd=0 counts as no write.
- Immediate:
  - I for OP-IMM, LOAD, JALR.
  - S for STORE.
  - B for BRANCH.
  - U for LUI, AUIPC.
  - J for JAL.
  - All immediates are sign-extended to 32 bits; otherwise the immediate is 0.
- Illegal: any opcode outside RV32I (incl. FENCE/SYSTEM as legal, no regs) sets `oIllegal`. The instruction still passes through with no register reads and writes.
- Scoreboard `sb[NRegs-1:1]`:
  - Set on capture of a writer.
  - Cleared by `iWbEn` or `iClrEn` for a matching nonzero address.
  - Set and clear of the same register in one cycle: set wins.
- Hazard: `stall` = a read operand hits `sb`, or the writer's rd hits `sb` (WAW).
- `oReady = nRst & !iFlush & !stall & (!oValid | iReady)`.
- Capture (`iValid & oReady`): load all ID/EX fields and set `oValid`.
- Handoff without capture: clear `oValid`.
- Flush:
  - Clears `oValid`.
  - If the held output had a nonzero `oRdAddr`, clears that `sb` bit.
  - Takes priority over capture.

## Timing
- Reset: `oValid`=0, every registered output 0, `sb`=0, `oReady`=0.
- Latency: accept in cycle N, output valid in cycle N+1.
- Throughput is 1/cycle when there are no hazards.
- `oValid` and its fields hold stable while `oValid & !iReady`.
- Hazard stall: `oReady` is low until the producer's writeback cycle. The earliest capture cycle depends on the bypass macro.
- `oAddr_Rs*` follows `iInstr` regardless of `oReady`.
- Reset asserted mid-stall or mid-handoff: all state clears immediately, with no pending writes kept.

## Configuration
- `DECODE_WB_BYPASS_EN` defined:
  - Hazard check uses `sb` with this cycle's clears applied.
  - An operand whose address equals `iWbAddr` while `iWbEn` is high, nonzero, takes `iWbData` instead of `iRs*`.
  - The dependent instruction is captured in the writeback cycle.
- Undefined:
  - Hazard check uses registered `sb` only, and operands always come from `iRs*`.
  - The dependent instruction is captured one cycle after writeback, when the register file holds the value.

## Test plan
- Reset, then stream `addi x1,x0,5` / `addi x2,x0,7` with `iReady`=1.
  - Required: `oValid` on cycles 1,2.
  - `oImm` = 5, 7; `oRdAddr` = 1, 2.
  - `sb[1]`, `sb[2]` set.
- `addi x3,x0,1` then `add x4,x3,x3`; writeback `x3=1` 4 cycles later.
  - Required: add stalls with `oReady`=0.
  - With bypass: captured in the WB cycle with `oRs1Val=oRs2Val=1`.
  - Without bypass: captured one cycle later.
- `iReady`=0 for 3 cycles while `oValid`.
  - Required: outputs held, `oReady`=0.
  - On release, the next instruction is captured the same cycle.
- Hold `lw x5,-4(x6)` in output, then assert `iFlush`.
  - Required: `oValid`=0 next cycle, `sb[5]` cleared.
  - The incoming instruction is not captured.
- `sw x7,8(x8)`, `beq x0,x0,-16`, `jal x1,2048`, opcode 0x7F.
  - Required: `oImm` = 8, 0xFFFFFFF0, 2048.
  - `oRdAddr` = 0, 0, 1.
  - `oIllegal` = 1 only for 0x7F.
- `addi x9,x0,1` then `iClrEn` with `iClrAddr=9`, then `addi x9,x0,2`.
  - Required: the second `addi` is not WAW-stalled after the clear.
  - `iClrEn` and capture in the same cycle leaves `sb[9]` set.

Source files
------------

// File: rtl/decode_stage.sv
// RV32I decode stage: valid/ready in, registered ID/EX out, per-register scoreboard for RAW/WAW stalls.
// Optional writeback bypass into hazard check and operands: define DECODE_WB_BYPASS_EN.

package rv32_isa;
  localparam int RegWidth     = 32;
  localparam int RegAddrWidth = 5;

  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpOpImm  = 7'b0010011;
  localparam logic [6:0] OpOp     = 7'b0110011;
  localparam logic [6:0] OpFence  = 7'b0001111;
  localparam logic [6:0] OpSystem = 7'b1110011;
endpackage

// One scoreboard bit; a set in the same cycle as a clear keeps the bit busy.
module decode_sb_cell (
  input  logic iClk,
  input  logic nRst,
  input  logic iSet,
  input  logic iClr,
  output logic oBusy,
  output logic oHaz
);
  logic busy;

  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst)     busy <= 1'b0;
    else if (iSet) busy <= 1'b1;
    else if (iClr) busy <= 1'b0;
  end

  assign oBusy = busy;
`ifdef DECODE_WB_BYPASS_EN
  assign oHaz = busy & ~iClr;
`else
  assign oHaz = busy;
`endif
endmodule

module decode_stage
  import rv32_isa::*;
#(
  parameter int NRegs = 32
) (
  input  logic                    iClk,
  input  logic                    nRst,
  input  logic                    iValid,
  output logic                    oReady,
  input  logic [31:0]             iInstr,
  input  logic [31:0]             iPC,
  output logic [RegAddrWidth-1:0] oAddr_Rs1,
  output logic [RegAddrWidth-1:0] oAddr_Rs2,
  input  logic [RegWidth-1:0]     iRs1,
  input  logic [RegWidth-1:0]     iRs2,
  input  logic                    iWbEn,
  input  logic [RegAddrWidth-1:0] iWbAddr,
  input  logic [RegWidth-1:0]     iWbData,
  input  logic                    iClrEn,
  input  logic [RegAddrWidth-1:0] iClrAddr,
  input  logic                    iFlush,
  output logic                    oValid,
  input  logic                    iReady,
  output logic [31:0]             oPC,
  output logic [RegWidth-1:0]     oRs1Val,
  output logic [RegWidth-1:0]     oRs2Val,
  output logic [31:0]             oImm,
  output logic [RegAddrWidth-1:0] oRdAddr,
  output logic [6:0]              oOpcode,
  output logic [2:0]              oFunct3,
  output logic                    oFunct7b5,
  output logic                    oIllegal
);

  logic [6:0]              opc;
  logic [RegAddrWidth-1:0] rs1, rs2, rd;
  logic                    rd_rs1, rd_rs2, writer, wr_rd, illegal;
  logic [31:0]             imm;
  logic [NRegs-1:0]        sb, sb_haz;
  logic                    stall, capture, flush_hit;
  logic [RegWidth-1:0]     rs1_val, rs2_val;

  assign opc = iInstr[6:0];
  assign rs1 = iInstr[19:15];
  assign rs2 = iInstr[24:20];
  assign rd  = iInstr[11:7];

  assign oAddr_Rs1 = rs1;
  assign oAddr_Rs2 = rs2;

  always_comb begin
    rd_rs1  = 1'b0;
    rd_rs2  = 1'b0;
    writer  = 1'b0;
    illegal = 1'b0;
    imm     = '0;
    unique case (opc)
      OpLui, OpAuipc: begin
        writer = 1'b1;
        imm    = {iInstr[31:12], 12'b0};
      end
      OpJal: begin
        writer = 1'b1;
        imm    = {{11{iInstr[31]}}, iInstr[31], iInstr[19:12], iInstr[20], iInstr[30:21], 1'b0};
      end
      OpJalr, OpLoad, OpOpImm: begin
        rd_rs1 = 1'b1;
        writer = 1'b1;
        imm    = {{20{iInstr[31]}}, iInstr[31:20]};
      end
      OpBranch: begin
        rd_rs1 = 1'b1;
        rd_rs2 = 1'b1;
        imm    = {{19{iInstr[31]}}, iInstr[31], iInstr[7], iInstr[30:25], iInstr[11:8], 1'b0};
      end
      OpStore: begin
        rd_rs1 = 1'b1;
        rd_rs2 = 1'b1;
        imm    = {{20{iInstr[31]}}, iInstr[31:25], iInstr[11:7]};
      end
      OpOp: begin
        rd_rs1 = 1'b1;
        rd_rs2 = 1'b1;
        writer = 1'b1;
      end
      OpFence, OpSystem: ;
      default: illegal = 1'b1;
    endcase
  end

  assign wr_rd = writer & (rd != '0);

  // x0 is never tracked, so reads or writes of x0 can never hit.
  assign sb[0]     = 1'b0;
  assign sb_haz[0] = 1'b0;
  assign flush_hit = iFlush & oValid;

  for (genvar r = 1; r < NRegs; r++) begin : g_sb
    localparam logic [RegAddrWidth-1:0] Idx = RegAddrWidth'(r);
    decode_sb_cell u_cell (
      .iClk  (iClk),
      .nRst  (nRst),
      .iSet  (capture & wr_rd & (rd == Idx)),
      .iClr  ((iWbEn & (iWbAddr == Idx)) | (iClrEn & (iClrAddr == Idx)) |
              (flush_hit & (oRdAddr == Idx))),
      .oBusy (sb[r]),
      .oHaz  (sb_haz[r])
    );
  end

  assign stall   = (rd_rs1 & sb_haz[rs1]) | (rd_rs2 & sb_haz[rs2]) | (wr_rd & sb_haz[rd]);
  assign oReady  = nRst & ~iFlush & ~stall & (~oValid | iReady);
  assign capture = iValid & oReady;

`ifdef DECODE_WB_BYPASS_EN
  logic byp1, byp2;
  assign byp1    = iWbEn & (iWbAddr != '0) & (iWbAddr == rs1);
  assign byp2    = iWbEn & (iWbAddr != '0) & (iWbAddr == rs2);
  assign rs1_val = rd_rs1 ? (byp1 ? iWbData : iRs1) : '0;
  assign rs2_val = rd_rs2 ? (byp2 ? iWbData : iRs2) : '0;
`else
  // Writeback data only matters when bypassing; operands wait for the register file.
  logic unused_wbdata;
  assign unused_wbdata = ^iWbData;
  assign rs1_val = rd_rs1 ? iRs1 : '0;
  assign rs2_val = rd_rs2 ? iRs2 : '0;
`endif

  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) begin
      oValid    <= 1'b0;
      oPC       <= '0;
      oRs1Val   <= '0;
      oRs2Val   <= '0;
      oImm      <= '0;
      oRdAddr   <= '0;
      oOpcode   <= '0;
      oFunct3   <= '0;
      oFunct7b5 <= 1'b0;
      oIllegal  <= 1'b0;
    end else if (iFlush) begin
      oValid <= 1'b0;
    end else if (capture) begin
      oValid    <= 1'b1;
      oPC       <= iPC;
      oRs1Val   <= rs1_val;
      oRs2Val   <= rs2_val;
      oImm      <= imm;
      oRdAddr   <= wr_rd ? rd : '0;
      oOpcode   <= opc;
      oFunct3   <= iInstr[14:12];
      oFunct7b5 <= iInstr[30];
      oIllegal  <= illegal;
    end else if (iReady) begin
      oValid <= 1'b0;
    end
  end

endmodule
